gfg_raster_write_arbiter: RTL and testbench
===========================================

Name: gfg_raster_write_arbiter

Overview:
Shares the single frame-buffer write port among NUM_RASTERIZERS rasterizers using round-robin, per-frame-sequenced write reservations. It sits between the rasterizer array and the frame-buffers controller/datapath. It grants one rasterizer at a time and muxes that rasterizer's write beats onto the frame-buffer port. It also reports to the controller when every rasterizer has finished the current frame.

Parameters:
NUM_RASTERIZERS, 4, number of requesters (>=1)
HORIZ_RESOLUTION, 80, frame-buffer columns
VERT_RESOLUTION, 60, frame-buffer rows
FRAME_BUFFER_WIDTH, 14, color+Z bits per pixel
HOLD_MAX, 16, max write beats per grant before forced release (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset
new_frame_initiated  in  1  controller pulse: a new frame may be drawn
req  in  NUM_RASTERIZERS  per-rasterizer reservation request (level)
release  in  NUM_RASTERIZERS  per-rasterizer 1-cycle pulse: give up grant
finished  in  NUM_RASTERIZERS  per-rasterizer level: done with this frame
wr_en  in  NUM_RASTERIZERS  per-rasterizer write strobe
vert_addr  in  NUM_RASTERIZERS*$clog2(VERT_RESOLUTION)  packed row addresses
horiz_addr  in  NUM_RASTERIZERS*$clog2(HORIZ_RESOLUTION)  packed column addresses
wr_data  in  NUM_RASTERIZERS*FRAME_BUFFER_WIDTH  packed pixel data
grant  out  NUM_RASTERIZERS  one-hot-or-zero reservation grant
fb_write_en  out  1  frame-buffer write strobe
fb_vert_addr  out  $clog2(VERT_RESOLUTION)  frame-buffer row
fb_horiz_addr  out  $clog2(HORIZ_RESOLUTION)  frame-buffer column
fb_write_data  out  FRAME_BUFFER_WIDTH  frame-buffer pixel
frame_done  out  1  all rasterizers finished; held until the next frame
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: clk rising edge with rst_n=0, synchronous, active-low. All outputs 0. State IDLE. RR pointer 0. Hold counter 0.
- IDLE: wait for new_frame_initiated=1, then go to ARB next cycle. frame_done clears on the same edge.
- ARB: scan req starting at the RR pointer, wrapping at NUM_RASTERIZERS. The first requester whose finished=0 wins.
  - grant[winner] is registered: high on the edge after ARB sees the request. Go to OWNED. Hold counter cleared.
  - No eligible request: stay in ARB.
- ARB, all finished=1: go to FRAME_DONE, whether or not any req is high.
- OWNED: the owner's wr_en=1 makes a beat.
  - Beat with vert_addr<VERT_RESOLUTION and horiz_addr<HORIZ_RESOLUTION: drive fb_write_en=1 with the owner's addr/data on the next cycle (1-cycle registered latency).
  - Out-of-range beats are dropped: fb_write_en=0.
  - wr_en from non-owners is ignored.
  - Each beat, in range or not, increments the hold counter.
- OWNED exit: owner release pulse, owner req dropping, or hold counter reaching HOLD_MAX. On exit:
  - grant falls on the next edge, then return to ARB.
  - RR pointer = owner+1 mod NUM_RASTERIZERS.
  - A beat coinciding with release or the HOLD_MAX-th beat is still written. Beats after that are dropped.
- Minimum gap between grants: 1 cycle in ARB.
- FRAME_DONE: frame_done=1 and grant=0. Next cycle go to IDLE; frame_done stays 1 until new_frame_initiated.
- new_frame_initiated in ARB/OWNED: ignored (controller guarantees it only after frame_done).
- release from non-owner: ignored.
- release and req rising in the same cycle: release has priority.
- rst_n=0 mid-grant: grant and fb_write_en drop on that edge. No pending write survives.
- NUM_RASTERIZERS=1: pointer stays 0. Behaviour is otherwise identical.

Optional Feature:
GFG_ARB_DROP_COUNT_EN: adds output drop_count[15:0].
- Increments on each dropped beat: out-of-range owner beat, non-owner wr_en, or a beat after the exit cycle.
- Saturates at 16'hFFFF. Cleared by reset and by new_frame_initiated.
- When undefined: no port, no counter logic.

Decomposition:
- Package gfg_pkg: FSM state enum (IDLE, ARB, OWNED, FRAME_DONE), address-width localparams from the resolutions, FRAME_BUFFER_WIDTH.
- One sub-module: gfg_rr_picker. Combinational rotate-priority encoder taking req & ~finished plus the pointer, returning a one-hot winner and a valid flag. It is reusable by future read-port arbitration.

Test Plan:
- Reset, then new_frame_initiated; req=4'b0110, finished=0 -> grant=4'b0010 two cycles after the pulse; after release, grant=4'b0100.
- Owner 0 writes (3,5) data 14'h1ABC -> next cycle fb_write_en=1, fb_vert_addr=3, fb_horiz_addr=5, fb_write_data=14'h1ABC; rasterizer 2 wr_en at the same time -> no extra write.
- HOLD_MAX=16, owner streams 20 beats -> exactly 16 fb writes, grant drops, RR passes the grant to the next requester.
- Owner write at horiz_addr=80 (HORIZ_RESOLUTION) -> fb_write_en stays 0; with GFG_ARB_DROP_COUNT_EN, drop_count=1.
- finished=4'b1111 while in ARB -> frame_done=1 and grant=0; busy=0 a cycle later; the next new_frame_initiated clears frame_done.
- rst_n=0 during OWNED with a beat in flight -> grant=0 and fb_write_en=0 on that edge; state IDLE.

Source files
------------

// File: rtl/gfg_pkg.sv
// Shared types and default geometry for the raster write-port arbiter.
// Optional drop counter is enabled by defining GFG_ARB_DROP_COUNT_EN.
package gfg_pkg;

    localparam int unsigned DEF_NUM_RASTERIZERS    = 4;
    localparam int unsigned DEF_HORIZ_RESOLUTION   = 80;
    localparam int unsigned DEF_VERT_RESOLUTION    = 60;
    localparam int unsigned DEF_FRAME_BUFFER_WIDTH = 14;
    localparam int unsigned DEF_HOLD_MAX           = 16;

    localparam int unsigned H_ADDR_W   = $clog2(DEF_HORIZ_RESOLUTION);
    localparam int unsigned V_ADDR_W   = $clog2(DEF_VERT_RESOLUTION);
    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARB        = 2'd1,
        OWNED      = 2'd2,
        FRAME_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/gfg_rr_picker.sv
// Rotating-priority encoder: first set request at or after ptr_i, wrapping.
module gfg_rr_picker #(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     win_c_o,
    output logic             valid_c_o
);

    // Scan N positions starting at the pointer; first hit wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        win_c_o   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_i) + k) % N;
            if (!found && req_i[PTR_W'(idx)]) begin
                win_c_o[PTR_W'(idx)] = 1'b1;
                found                = 1'b1;
            end
        end
        valid_c_o = found;
    end

endmodule

// File: rtl/gfg_raster_write_arbiter.sv
// Round-robin owner of the frame-buffer write port with per-frame sequencing.
// Define GFG_ARB_DROP_COUNT_EN to add the drop_count_o statistics output.
module gfg_raster_write_arbiter
    import gfg_pkg::*;
#(
    parameter  int unsigned NUM_RASTERIZERS    = DEF_NUM_RASTERIZERS,
    parameter  int unsigned HORIZ_RESOLUTION   = DEF_HORIZ_RESOLUTION,
    parameter  int unsigned VERT_RESOLUTION    = DEF_VERT_RESOLUTION,
    parameter  int unsigned FRAME_BUFFER_WIDTH = DEF_FRAME_BUFFER_WIDTH,
    parameter  int unsigned HOLD_MAX           = DEF_HOLD_MAX,
    localparam int unsigned N                  = NUM_RASTERIZERS,
    localparam int unsigned VW                 = $clog2(VERT_RESOLUTION),
    localparam int unsigned HW                 = $clog2(HORIZ_RESOLUTION),
    localparam int unsigned DW                 = FRAME_BUFFER_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            new_frame_initiated_i,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    release_i,
    input  logic [N-1:0]    finished_i,
    input  logic [N-1:0]    wr_en_i,
    input  logic [N*VW-1:0] vert_addr_i,
    input  logic [N*HW-1:0] horiz_addr_i,
    input  logic [N*DW-1:0] wr_data_i,
    output logic [N-1:0]    grant_o,
    output logic            fb_write_en_o,
    output logic [VW-1:0]   fb_vert_addr_o,
    output logic [HW-1:0]   fb_horiz_addr_o,
    output logic [DW-1:0]   fb_write_data_o,
    output logic            frame_done_o,
`ifdef GFG_ARB_DROP_COUNT_EN
    output logic [15:0]     drop_count_o,
`endif
    output logic            busy_o
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

    state_e           state_q;
    logic [PTR_W-1:0] ptr_q, owner_q, win_idx, ptr_next;
    logic [CNT_W-1:0] hold_q;
    logic [N-1:0]     grant_q, win;
    logic             win_valid;
    logic             fb_we_q, frame_done_q, busy_q;
    logic [VW-1:0]    fb_v_q, own_v;
    logic [HW-1:0]    fb_h_q, own_h;
    logic [DW-1:0]    fb_d_q, own_d;
    logic             own_req, own_rel, own_wr;
    logic             in_range, beat, last_beat, owner_exit, do_write;

    gfg_rr_picker #(.N(N)) u_picker (
        .req_i     (req_i & ~finished_i),
        .ptr_i     (ptr_q),
        .win_c_o   (win),
        .valid_c_o (win_valid)
    );

    // One-hot winner to index for the owner register.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

    // Select the current owner's request, release and write lane.
    always_comb begin
        own_req = 1'b0;
        own_rel = 1'b0;
        own_wr  = 1'b0;
        own_v   = '0;
        own_h   = '0;
        own_d   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (owner_q == PTR_W'(i)) begin
                own_req = req_i[i];
                own_rel = release_i[i];
                own_wr  = wr_en_i[i];
                own_v   = vert_addr_i[i*VW +: VW];
                own_h   = horiz_addr_i[i*HW +: HW];
                own_d   = wr_data_i[i*DW +: DW];
            end
        end
    end

    // Beat qualification and exit conditions while a grant is held.
    always_comb begin
        in_range   = ({1'b0, own_v} < (VW+1)'(VERT_RESOLUTION)) &&
                     ({1'b0, own_h} < (HW+1)'(HORIZ_RESOLUTION));
        beat       = (state_q == OWNED) && own_wr;
        last_beat  = beat && (hold_q == CNT_W'(HOLD_MAX - 1));
        owner_exit = (state_q == OWNED) && (own_rel || !own_req || last_beat);
        do_write   = beat && in_range;
        ptr_next   = (owner_q == PTR_W'(N - 1)) ? '0 : owner_q + PTR_W'(1);
    end

    // Arbitration FSM with registered grant, write port and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            hold_q       <= '0;
            grant_q      <= '0;
            fb_we_q      <= 1'b0;
            fb_v_q       <= '0;
            fb_h_q       <= '0;
            fb_d_q       <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            fb_we_q <= do_write;
            if (do_write) begin
                fb_v_q <= own_v;
                fb_h_q <= own_h;
                fb_d_q <= own_d;
            end
            case (state_q)
                IDLE: begin
                    if (new_frame_initiated_i) begin
                        state_q      <= ARB;
                        frame_done_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                ARB: begin
                    if (&finished_i) begin
                        state_q      <= FRAME_DONE;
                        frame_done_q <= 1'b1;
                    end else if (win_valid) begin
                        state_q <= OWNED;
                        grant_q <= win;
                        owner_q <= win_idx;
                        hold_q  <= '0;
                    end
                end
                OWNED: begin
                    if (beat) hold_q <= hold_q + CNT_W'(1);
                    if (owner_exit) begin
                        state_q <= ARB;
                        grant_q <= '0;
                        ptr_q   <= ptr_next;
                    end
                end
                FRAME_DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef GFG_ARB_DROP_COUNT_EN
    logic [15:0] drop_q;
    logic [16:0] drop_sum;
    logic [N-1:0] dropped;

    // Count every strobe that does not become a frame-buffer write, saturating.
    always_comb begin
        dropped  = wr_en_i & ~(do_write ? grant_q : '0);
        drop_sum = {1'b0, drop_q};
        for (int i = 0; i < int'(N); i++) begin
            if (dropped[i]) drop_sum = drop_sum + 17'd1;
        end
    end

    // Drop counter register, cleared at frame start.
    always_ff @(posedge clk) begin
        if (!rst_n || new_frame_initiated_i) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign drop_count_o = drop_q;
`endif

    assign grant_o         = grant_q;
    assign fb_write_en_o   = fb_we_q;
    assign fb_vert_addr_o  = fb_v_q;
    assign fb_horiz_addr_o = fb_h_q;
    assign fb_write_data_o = fb_d_q;
    assign frame_done_o    = frame_done_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_gfg_raster_write_arbiter.sv
// Directed bench for the raster write-port arbiter (default geometry 4x80x60x14).
module tb_gfg_raster_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_frame;
    logic [3:0]  req, rel, fin, wr_en;
    logic [23:0] vert_addr;
    logic [27:0] horiz_addr;
    logic [55:0] wr_data;
    logic [3:0]  grant;
    logic        fb_we, frame_done, busy;
    logic [5:0]  fb_v;
    logic [6:0]  fb_h;
    logic [13:0] fb_d;
`ifdef GFG_ARB_DROP_COUNT_EN
    logic [15:0] drop_count;
    logic [15:0] drop_before;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gfg_raster_write_arbiter dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .new_frame_initiated_i (new_frame),
        .req_i                 (req),
        .release_i             (rel),
        .finished_i            (fin),
        .wr_en_i               (wr_en),
        .vert_addr_i           (vert_addr),
        .horiz_addr_i          (horiz_addr),
        .wr_data_i             (wr_data),
        .grant_o               (grant),
        .fb_write_en_o         (fb_we),
        .fb_vert_addr_o        (fb_v),
        .fb_horiz_addr_o       (fb_h),
        .fb_write_data_o       (fb_d),
        .frame_done_o          (frame_done),
`ifdef GFG_ARB_DROP_COUNT_EN
        .drop_count_o          (drop_count),
`endif
        .busy_o                (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [5:0] v, input logic [6:0] h,
                            input logic [13:0] d);
        vert_addr[i*6 +: 6]   = v;
        horiz_addr[i*7 +: 7]  = h;
        wr_data[i*14 +: 14]   = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; new_frame = 1'b0; req = '0; rel = '0; fin = '0; wr_en = '0;
        vert_addr = '0; horiz_addr = '0; wr_data = '0;
        tick(); tick();
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL reset_fb_we: got %b expected 0", fb_we); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (fb_d !== 14'h0) begin miscompares++; $display("FAIL reset_fb_data: got %h expected 0000", fb_d); end
        rst_n = 1'b1;
    endtask

    task automatic test_rr_grant();
        new_frame = 1'b1; req = 4'b0110;
        tick();
        new_frame = 1'b0;
        vectors++; if (busy !== 1'b1 || grant !== 4'b0000) begin miscompares++; $display("FAIL arb_entry: got busy=%b grant=%b expected busy=1 grant=0000", busy, grant); end
        tick();
        vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL first_grant: got %b expected 0010", grant); end
        rel = 4'b0010;
        tick();
        rel = '0;
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL release_gap: got %b expected 0000", grant); end
        tick();
        vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL rr_next_grant: got %b expected 0100", grant); end
        req = 4'b0001; rel = 4'b0100;
        tick();
        rel = '0;
        tick();
        vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL wrap_grant: got %b expected 0001", grant); end
    endtask

    task automatic test_write_mux();
        set_lane(0, 6'd3, 7'd5, 14'h1ABC);
        set_lane(2, 6'd7, 7'd9, 14'h0555);
        wr_en = 4'b0101;
        tick();
        wr_en = '0;
        vectors++; if (fb_we !== 1'b1) begin miscompares++; $display("FAIL mux_we: got %b expected 1", fb_we); end
        vectors++; if (fb_v !== 6'd3) begin miscompares++; $display("FAIL mux_vert: got %0d expected 3", fb_v); end
        vectors++; if (fb_h !== 7'd5) begin miscompares++; $display("FAIL mux_horiz: got %0d expected 5", fb_h); end
        vectors++; if (fb_d !== 14'h1ABC) begin miscompares++; $display("FAIL mux_data: got %h expected 1abc", fb_d); end
        tick();
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL no_extra_write: got %b expected 0", fb_we); end
    endtask

    task automatic test_out_of_range();
`ifdef GFG_ARB_DROP_COUNT_EN
        drop_before = drop_count;
`endif
        set_lane(0, 6'd3, 7'd80, 14'h0F0F);
        wr_en = 4'b0001;
        tick();
        wr_en = '0;
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL oor_we: got %b expected 0", fb_we); end
        vectors++; if (fb_h !== 7'd5) begin miscompares++; $display("FAIL oor_hold_addr: got %0d expected 5", fb_h); end
`ifdef GFG_ARB_DROP_COUNT_EN
        vectors++; if (drop_count !== drop_before + 16'd1) begin miscompares++; $display("FAIL oor_drop_count: got %0d expected %0d", drop_count, drop_before + 16'd1); end
`endif
    endtask

    task automatic test_hold_max();
        int writes;
        writes = 0;
        req = 4'b0011; rel = 4'b0001;
        tick();
        rel = '0;
        tick();
        vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL hold_owner: got %b expected 0010", grant); end
        for (int k = 0; k < 20; k++) begin
            set_lane(1, 6'(k), 7'(k + 1), 14'(k));
            wr_en = 4'b0010;
            tick();
            if (fb_we === 1'b1) writes++;
            if (k == 15) begin
                vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL hold_release: got %b expected 0000", grant); end
            end
            if (k == 16) begin
                vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL hold_rr_pass: got %b expected 0001", grant); end
            end
        end
        wr_en = '0;
        vectors++; if (writes !== 16) begin miscompares++; $display("FAIL hold_write_count: got %0d expected 16", writes); end
        vectors++; if (fb_d !== 14'd15) begin miscompares++; $display("FAIL hold_last_data: got %0d expected 15", fb_d); end
    endtask

    task automatic test_frame_done();
        rel = 4'b0001; req = '0; fin = 4'b1111;
        tick();
        rel = '0;
        tick();
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL fd_flag: got %b expected 1", frame_done); end
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL fd_grant: got %b expected 0000", grant); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fd_busy_state: got %b expected 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fd_idle_busy: got %b expected 0", busy); end
        tick();
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL fd_held: got %b expected 1", frame_done); end
        new_frame = 1'b1; fin = '0;
        tick();
        new_frame = 1'b0;
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL fd_clear: got %b expected 0", frame_done); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fd_rearm_busy: got %b expected 1", busy); end
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b0001;
        tick();
        vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL rst_pre_grant: got %b expected 0001", grant); end
        set_lane(0, 6'd10, 7'd20, 14'h2222);
        wr_en = 4'b0001; rst_n = 1'b0;
        tick();
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL rst_grant: got %b expected 0000", grant); end
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL rst_fb_we: got %b expected 0", fb_we); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst_n = 1'b1; wr_en = '0;
        tick();
        vectors++; if (fb_we !== 1'b0 || grant !== 4'b0000) begin miscompares++; $display("FAIL rst_no_pending: got we=%b grant=%b expected we=0 grant=0000", fb_we, grant); end
    endtask

    initial begin
        test_reset();
        test_rr_grant();
        test_write_mux();
        test_out_of_range();
        test_hold_max();
        test_frame_done();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
